// File: rtl/rtc_read_sequencer.sv
// rtl/rtc_read_sequencer.sv - periodic six-register RTC read sweep with atomic snapshot commit
module rtc_read_sequencer #(
    parameter int         TICK_DIV = 50_000_000,
    parameter int         TIMEOUT  = 255,
    parameter logic [7:0] ADDR_SEC = 8'h21
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       enable,
    output logic       rd_start,
    output logic [7:0] rd_addr,
    input  logic       rd_done,
    input  logic [7:0] rd_data,
    output logic [7:0] sec,
    output logic [7:0] min,
    output logic [7:0] hour,
    output logic [7:0] day,
    output logic [7:0] month,
    output logic [7:0] year,
    output logic       snap_valid,
    output logic       busy,
    output logic       err
);
    localparam int TW = $clog2(TICK_DIV);
    localparam int WW = $clog2(TIMEOUT) + 1;
    localparam logic [TW-1:0] TICK_LAST = TW'(TICK_DIV - 1);
    localparam logic [WW-1:0] WAIT_LAST = WW'(TIMEOUT - 1);
    localparam logic [2:0]    IDX_LAST  = 3'd5;

    typedef enum logic [2:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT,
        S_NEXT,
        S_COMMIT
    } state_t;

    state_t        state, state_d;
    logic [2:0]    idx, idx_d;
    logic [WW-1:0] wait_cnt, wait_d;
    logic [TW-1:0] tick_cnt;
    logic          pending;
    logic          tick_wrap;
    logic          take_pending;
    logic          capture;
    logic          commit;
    logic          timeout_hit;
    logic [7:0]    shadow [6];

    assign tick_wrap  = enable && (tick_cnt == TICK_LAST);
    // Gated by reset so a request never leaks out on the cycle the sweep is being killed.
    assign rd_start   = (state == S_ISSUE) && reset;
    assign snap_valid = (state == S_COMMIT);
    assign busy       = (state != S_IDLE);

    always_comb begin
        state_d      = state;
        idx_d        = idx;
        wait_d       = wait_cnt;
        take_pending = 1'b0;
        capture      = 1'b0;
        commit       = 1'b0;
        timeout_hit  = 1'b0;
        case (state)
            S_IDLE: begin
                if (pending) begin
                    take_pending = 1'b1;
                    idx_d        = 3'd0;
                    state_d      = S_ISSUE;
                end
            end
            S_ISSUE: begin
                wait_d  = '0;
                state_d = S_WAIT;
            end
            S_WAIT: begin
                if (rd_done) begin
                    capture = 1'b1;
                    state_d = S_NEXT;
                end else if (wait_cnt == WAIT_LAST) begin
                    timeout_hit = 1'b1;
                    state_d     = S_IDLE;
                end else begin
                    wait_d = wait_cnt + WW'(1);
                end
            end
            S_NEXT: begin
                if (idx == IDX_LAST) begin
                    commit  = 1'b1;
                    state_d = S_COMMIT;
                end else begin
                    idx_d   = idx + 3'd1;
                    state_d = S_ISSUE;
                end
            end
            S_COMMIT: state_d = S_IDLE;
            default:  state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (capture) begin
            shadow[idx] <= rd_data;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state    <= S_IDLE;
            idx      <= 3'd0;
            wait_cnt <= '0;
            tick_cnt <= '0;
            pending  <= 1'b0;
            rd_addr  <= 8'h00;
            sec      <= 8'h00;
            min      <= 8'h00;
            hour     <= 8'h00;
            day      <= 8'h00;
            month    <= 8'h00;
            year     <= 8'h00;
            err      <= 1'b0;
        end else begin
            state    <= state_d;
            idx      <= idx_d;
            wait_cnt <= wait_d;
            if (enable) begin
                tick_cnt <= tick_wrap ? '0 : tick_cnt + TW'(1);
            end
            // A wrap coinciding with consumption re-arms, so that tick is not lost.
            pending <= tick_wrap | (pending & ~take_pending);
            if (state_d == S_ISSUE) begin
                rd_addr <= ADDR_SEC + {5'd0, idx_d};
            end
            if (timeout_hit) begin
                err <= 1'b1;
            end
            // Outputs load on entry to COMMIT so they change in the snap_valid cycle.
            if (commit) begin
                sec   <= shadow[0];
                min   <= shadow[1];
                hour  <= shadow[2];
                day   <= shadow[3];
                month <= shadow[4];
                year  <= shadow[5];
                err   <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_rtc_read_sequencer.sv
// tb/tb_rtc_read_sequencer.sv - scoreboard bench for rtc_read_sequencer
module tb_rtc_read_sequencer;
    localparam int TICK_DIV = 16;
    localparam int TIMEOUT  = 48;
    localparam logic [7:0]  ADDR_SEC = 8'h21;
    localparam logic [47:0] T1_SNAP  = {8'h16, 8'h04, 8'h07, 8'h12, 8'h30, 8'h59};

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       enable = 1'b0;
    logic       rd_start;
    logic [7:0] rd_addr;
    logic       rd_done;
    logic [7:0] rd_data;
    logic [7:0] sec, min, hour, day, month, year;
    logic       snap_valid, busy, err;

    logic       resp_done = 1'b0;
    logic [7:0] resp_data = 8'h00;
    logic       spur_done = 1'b0;
    logic [7:0] spur_data = 8'h00;
    assign rd_done = resp_done | spur_done;
    assign rd_data = spur_done ? spur_data : resp_data;

    logic [47:0] dut_snap;
    assign dut_snap = {year, month, day, hour, min, sec};

    rtc_read_sequencer #(.TICK_DIV(TICK_DIV), .TIMEOUT(TIMEOUT), .ADDR_SEC(ADDR_SEC)) dut (
        .clk(clk), .reset(reset), .enable(enable),
        .rd_start(rd_start), .rd_addr(rd_addr), .rd_done(rd_done), .rd_data(rd_data),
        .sec(sec), .min(min), .hour(hour), .day(day), .month(month), .year(year),
        .snap_valid(snap_valid), .busy(busy), .err(err)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_checks = 0;
    int n_pass   = 0;

    typedef struct {
        int          at;
        logic [47:0] data;
    } snap_t;

    snap_t       snapq[$];
    int          errq[$];
    logic [47:0] committed = '0;
    bit          model_err = 1'b0;
    bit          mon_on = 1'b0;

    bit          fixed_mode = 1'b0;
    bit          fixed_data = 1'b0;
    int          cfg_delay = 3;
    logic [7:0]  silent_addr = 8'h00;
    logic [47:0] t1_table = T1_SNAP;

    task automatic check(input string name, input logic [47:0] act, input logic [47:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    endtask

    // Responder and model of a sweep: six in-order reads succeed iff each answers within TIMEOUT.
    initial begin : responder
        int k, last_start, last_d, c, d, r;
        bit silent, aborted;
        logic [7:0] a, dat, ea;
        logic [47:0] bytes;
        snap_t s;
        k = 0; last_start = 0; last_d = 0; bytes = '0;
        forever begin
            @(negedge clk);
            resp_done = 1'b0;
            if (mon_on && rd_start) begin
                c  = cyc;
                a  = rd_addr;
                ea = ADDR_SEC + 8'(k);
                check("rd_addr_order", 48'(a), 48'(ea));
                if (k > 0) check("issue_interval", 48'(c - last_start), 48'(last_d + 2));
                silent = 1'b0;
                d = 1;
                if (silent_addr != 8'h00 && a == silent_addr) silent = 1'b1;
                else if (fixed_mode) d = cfg_delay;
                else begin
                    r = int'($urandom_range(0, 19));
                    if (r == 0) silent = 1'b1;
                    else if (r == 1) d = TIMEOUT;
                    else d = int'($urandom_range(1, 6));
                end
                dat = fixed_data ? t1_table[8*k +: 8] : 8'($urandom);
                if (silent) begin
                    errq.push_back(c + TIMEOUT + 1);
                    k = 0;
                end else begin
                    aborted = 1'b0;
                    for (int i = 0; i < d; i++) begin
                        @(negedge clk);
                        if (!busy) aborted = 1'b1;
                    end
                    if (!aborted) check("rd_addr_held", 48'(rd_addr), 48'(a));
                    resp_done = 1'b1;
                    resp_data = dat;
                    if (aborted) k = 0;
                    else begin
                        bytes[8*k +: 8] = dat;
                        k++;
                        last_start = c;
                        last_d = d;
                        if (k == 6) begin
                            s.at = c + d + 2;
                            s.data = bytes;
                            snapq.push_back(s);
                            k = 0;
                        end
                    end
                end
            end
        end
    end

    initial begin : monitor
        bit exp_sv;
        snap_t s;
        forever begin
            @(negedge clk);
            if (mon_on) begin
                while (snapq.size() > 0 && snapq[0].at < cyc) void'(snapq.pop_front());
                exp_sv = 1'b0;
                if (snapq.size() > 0 && snapq[0].at == cyc) begin
                    s = snapq.pop_front();
                    committed = s.data;
                    model_err = 1'b0;
                    exp_sv = 1'b1;
                end
                while (errq.size() > 0 && errq[0] <= cyc) begin
                    void'(errq.pop_front());
                    model_err = 1'b1;
                end
                check("snap_valid", 48'(snap_valid), 48'(exp_sv));
                check("snapshot", dut_snap, committed);
                check("err", 48'(err), 48'(model_err));
                if (!reset) begin
                    committed = '0;
                    model_err = 1'b0;
                    snapq.delete();
                    errq.delete();
                end
            end
        end
    end

    task automatic drive_edge();
        @(posedge clk);
        #2;
    endtask

    task automatic wait_start(input string name, input logic [7:0] addr, input int bound,
                              output int c, output bit ok);
        ok = 1'b0;
        c = 0;
        for (int i = 0; i < bound; i++) begin
            @(negedge clk);
            if (rd_start && (addr == 8'h00 || rd_addr == addr)) begin
                c = cyc;
                ok = 1'b1;
                break;
            end
        end
        if (!ok) check(name, 48'(0), 48'(1));
    endtask

    task automatic wait_snap(input string name, input int bound, output int t, output bit ok);
        ok = 1'b0;
        t = 0;
        for (int i = 0; i < bound; i++) begin
            @(negedge clk);
            if (snap_valid) begin
                t = cyc;
                ok = 1'b1;
                break;
            end
        end
        if (!ok) check(name, 48'(0), 48'(1));
    endtask

    task automatic wait_quiet(input string name);
        int quiet = 0;
        for (int i = 0; i < 2000 && quiet < 40; i++) begin
            @(negedge clk);
            quiet = busy ? 0 : quiet + 1;
        end
        check(name, 48'(quiet >= 40), 48'(1));
    endtask

    task automatic count_activity(input int n, output int starts, output int snaps);
        starts = 0;
        snaps = 0;
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            if (rd_start) starts++;
            if (snap_valid) snaps++;
        end
    endtask

    initial begin : stimulus
        int c, e, t, starts, snaps;
        bit ok;
        repeat (3) @(posedge clk);
        #2;
        reset = 1'b1;
        mon_on = 1'b1;
        @(negedge clk);
        check("reset_rd_start", 48'(rd_start), 48'(0));
        check("reset_rd_addr", 48'(rd_addr), 48'(0));
        check("reset_busy", 48'(busy), 48'(0));
        check("reset_snapshot", dut_snap, 48'(0));

        // Disabled: nothing happens; then first request TICK_DIV+1 cycles after enable.
        count_activity(100, starts, snaps);
        check("disabled_no_start", 48'(starts), 48'(0));
        drive_edge();
        e = cyc;
        fixed_mode = 1'b1;
        cfg_delay = 3;
        fixed_data = 1'b1;
        enable = 1'b1;
        wait_start("first_start_bound", 8'h00, 100, c, ok);
        if (ok) check("first_start_latency", 48'(c), 48'(e + TICK_DIV + 1));
        drive_edge();
        enable = 1'b0;
        wait_snap("t1_snap_bound", 200, t, ok);
        if (ok) check("t1_snapshot", dut_snap, T1_SNAP);
        count_activity(60, starts, snaps);
        check("t1_single_sweep", 48'(starts + snaps), 48'(0));
        fixed_data = 1'b0;

        // Spurious rd_done while idle.
        drive_edge();
        spur_done = 1'b1;
        spur_data = 8'hAA;
        drive_edge();
        spur_done = 1'b0;
        count_activity(5, starts, snaps);
        check("spurious_no_snap", 48'(snaps), 48'(0));
        check("spurious_no_change", dut_snap, T1_SNAP);

        // Silent third register: timeout, snapshot kept, next good sweep clears err.
        silent_addr = 8'h23;
        drive_edge();
        enable = 1'b1;
        wait_start("t2_start_bound", 8'h23, 200, c, ok);
        drive_edge();
        enable = 1'b0;
        if (ok) begin
            ok = 1'b0;
            for (int i = 0; i < TIMEOUT + 20; i++) begin
                @(negedge clk);
                if (err) begin
                    t = cyc;
                    ok = 1'b1;
                    break;
                end
            end
            check("timeout_seen", 48'(ok), 48'(1));
            if (ok) check("timeout_latency", 48'(t), 48'(c + TIMEOUT + 1));
            check("snapshot_kept", dut_snap, T1_SNAP);
        end
        silent_addr = 8'h00;
        drive_edge();
        enable = 1'b1;
        wait_snap("t2_recover_bound", 400, t, ok);
        if (ok) check("err_cleared", 48'(err), 48'(0));
        drive_edge();
        enable = 1'b0;
        wait_quiet("t2_quiet");

        // Slow responder: exactly one back-to-back sweep with one idle cycle between.
        cfg_delay = 40;
        drive_edge();
        enable = 1'b1;
        wait_snap("t3_snap_bound", 800, t, ok);
        drive_edge();
        enable = 1'b0;
        if (ok) begin
            @(negedge clk);
            check("gap_busy_low", 48'(busy), 48'(0));
            @(negedge clk);
            check("gap_restart", 48'({busy, rd_start}), 48'(2'b11));
            wait_snap("t3_second_bound", 800, t, ok);
            count_activity(60, starts, snaps);
            check("t3_no_third_sweep", 48'(starts), 48'(0));
        end

        // Randomized delays, data, timeouts and enable toggling.
        fixed_mode = 1'b0;
        drive_edge();
        enable = 1'b1;
        for (int i = 0; i < 3000; i++) begin
            drive_edge();
            if ($urandom_range(0, 199) == 0) enable = ~enable;
        end
        enable = 1'b0;
        wait_quiet("random_quiet");

        // Reset while waiting on the fourth register; the late rd_done is ignored.
        fixed_mode = 1'b1;
        cfg_delay = 8;
        drive_edge();
        enable = 1'b1;
        wait_start("t4_start_bound", 8'h24, 400, c, ok);
        if (ok) begin
            drive_edge();
            reset = 1'b0;
            enable = 1'b0;
            drive_edge();
            reset = 1'b1;
            @(negedge clk);
            check("t4_busy", 48'(busy), 48'(0));
            check("t4_rd_addr", 48'(rd_addr), 48'(0));
            check("t4_snapshot", dut_snap, 48'(0));
            count_activity(12, starts, snaps);
            check("t4_late_done_ignored", 48'(starts + snaps), 48'(0));
            check("t4_snapshot_after", dut_snap, 48'(0));
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin : watchdog
        #600000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1);
    end
endmodule
